// File: rtl/mult_rr_scheduler_if.sv
// Bundles the requester handshakes, the shared-multiplier operand/product path
// and the result/status outputs of the round-robin multiplier scheduler.
interface mult_rr_scheduler_if #(
  parameter int WIDTH = 40,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid_in;
  logic [NREQ*WIDTH-1:0] req_a_in;
  logic [NREQ*WIDTH-1:0] req_b_in;
  logic [NREQ-1:0]       req_ready_out;
  logic [WIDTH-1:0]      mult_a_out;
  logic [WIDTH-1:0]      mult_b_out;
  logic [2*WIDTH-1:0]    mult_pdt_in;
  logic [NREQ-1:0]       res_valid_out;
  logic [IDW-1:0]        res_id_out;
  logic [2*WIDTH-1:0]    res_pdt_out;
  logic [15:0]           issue_count_out;

  // The scheduler side.
  modport slave (
    input  req_valid_in, req_a_in, req_b_in, mult_pdt_in,
    output req_ready_out, mult_a_out, mult_b_out,
           res_valid_out, res_id_out, res_pdt_out, issue_count_out
  );

  // The clients plus the multiplier, seen from outside the scheduler.
  modport master (
    output req_valid_in, req_a_in, req_b_in, mult_pdt_in,
    input  req_ready_out, mult_a_out, mult_b_out,
           res_valid_out, res_id_out, res_pdt_out, issue_count_out
  );
endinterface

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one fixed-latency pipelined multiplier among
// NREQ requesters; a tag pipeline routes each product back to its originator.
module mult_rr_scheduler #(
  parameter int WIDTH   = 40,
  parameter int NREQ    = 4,
  parameter int LATENCY = 3,
  parameter int IDW     = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  mult_rr_scheduler_if.slave   bus
);

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]   mult_a_q, mult_a_d;
  logic [WIDTH-1:0]   mult_b_q, mult_b_d;
  tag_t               tag_q [LATENCY+1];
  tag_t               tag0_d;
  logic [NREQ-1:0]    res_valid_q, res_valid_d;
  logic [IDW-1:0]     res_id_q, res_id_d;
  logic [2*WIDTH-1:0] res_pdt_q, res_pdt_d;
  logic [15:0]        issue_cnt_q, issue_cnt_d;

  logic [NREQ-1:0]    grant;
  logic [IDW-1:0]     grant_id;
  logic               xfer;

  // Search upward from rr_ptr, wrapping modulo NREQ; first valid wins.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    grant    = '0;
    grant_id = '0;
    xfer     = 1'b0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!xfer && bus.req_valid_in[IDW'(idx)]) begin
        grant[IDW'(idx)] = 1'b1;
        grant_id         = IDW'(idx);
        xfer             = 1'b1;
      end
    end
    if (!rst_n_in) begin
      grant = '0;
      xfer  = 1'b0;
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    mult_a_d    = '0;
    mult_b_d    = '0;
    tag0_d      = '0;
    issue_cnt_d = issue_cnt_q;
    if (xfer) begin
      mult_a_d    = bus.req_a_in[int'(grant_id)*WIDTH +: WIDTH];
      mult_b_d    = bus.req_b_in[int'(grant_id)*WIDTH +: WIDTH];
      rr_ptr_d    = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
      tag0_d      = '{valid: 1'b1, id: grant_id};
      issue_cnt_d = issue_cnt_q + 16'd1;
    end
  end

  // The last tag stage lines up with the product of the same operation.
  always_comb begin
    res_valid_d = '0;
    res_id_d    = tag_q[LATENCY].id;
    res_pdt_d   = '0;
    if (tag_q[LATENCY].valid) begin
      res_valid_d = NREQ'(1) << tag_q[LATENCY].id;
      res_pdt_d   = bus.mult_pdt_in;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rr_ptr_q    <= '0;
      mult_a_q    <= '0;
      mult_b_q    <= '0;
      res_valid_q <= '0;
      res_id_q    <= '0;
      res_pdt_q   <= '0;
      issue_cnt_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      mult_a_q    <= mult_a_d;
      mult_b_q    <= mult_b_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_pdt_q   <= res_pdt_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  // NOTE: the tag chain is a handful of flops, not a RAM, so it is fully reset;
  // clearing the valid bits is what discards operations in flight at reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int s = 0; s <= LATENCY; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= tag0_d;
      for (int s = 1; s <= LATENCY; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign bus.req_ready_out   = grant;
  assign bus.mult_a_out      = mult_a_q;
  assign bus.mult_b_out      = mult_b_q;
  assign bus.res_valid_out   = res_valid_q;
  assign bus.res_id_out      = res_id_q;
  assign bus.res_pdt_out     = res_pdt_q;
  assign bus.issue_count_out = issue_cnt_q;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Bench for mult_rr_scheduler: directed and random requests, an ideal pipelined
// multiplier, and a transaction-level reference model of grants and results.
module tb_mult_rr_scheduler;
  localparam int WIDTH   = 40;
  localparam int NREQ    = 4;
  localparam int LATENCY = 3;
  localparam int IDW     = 2;
  localparam int PW      = 2 * WIDTH;

  typedef struct {
    int            due;
    int            id;
    logic [PW-1:0] pdt;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_rr_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

  mult_rr_scheduler #(
    .WIDTH(WIDTH), .NREQ(NREQ), .LATENCY(LATENCY), .IDW(IDW)
  ) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  // Ideal multiplier: product of the registered operands appears LATENCY edges later.
  logic [PW-1:0] pipe [LATENCY];
  always @(posedge clk) begin
    pipe[0] <= PW'(bus.mult_a_out) * PW'(bus.mult_b_out);
    for (int k = 1; k < LATENCY; k++) pipe[k] <= pipe[k-1];
  end
  assign bus.mult_pdt_in = pipe[LATENCY-1];

  // Requester state and reference model.
  bit               v [NREQ];
  logic [WIDTH-1:0] a [NREQ];
  logic [WIDTH-1:0] b [NREQ];
  int               rr;
  logic [15:0]      cnt;
  exp_t             q [$];
  int               cyc;
  int               checks;
  int               errors;

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid_in[i]              = v[i];
      bus.req_a_in[i*WIDTH +: WIDTH]   = a[i];
      bus.req_b_in[i*WIDTH +: WIDTH]   = b[i];
    end
  endtask

  // One clock cycle, entered and left at a falling edge; g is the granted index or -1.
  task automatic cycle(output int g);
    exp_t            e;
    logic [NREQ-1:0] er;
    int              idx;
    drive();
    #1;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (rr + k) % NREQ;
      if (g < 0 && v[idx]) g = idx;
    end
    er = (g >= 0) ? NREQ'(1) << g : '0;
    check("req_ready", PW'(bus.req_ready_out), PW'(er));
    @(posedge clk);
    #1;
    cyc++;
    if (g >= 0) begin
      rr    = (g + 1) % NREQ;
      cnt   = cnt + 16'd1;
      e.due = cyc + LATENCY + 1;
      e.id  = g;
      e.pdt = PW'(a[g]) * PW'(b[g]);
      q.push_back(e);
    end
    check("mult_a", PW'(bus.mult_a_out), (g >= 0) ? PW'(a[g]) : '0);
    check("mult_b", PW'(bus.mult_b_out), (g >= 0) ? PW'(b[g]) : '0);
    check("issue_count", PW'(bus.issue_count_out), PW'(cnt));
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      check("res_valid", PW'(bus.res_valid_out), PW'(NREQ'(1) << e.id));
      check("res_id", PW'(bus.res_id_out), PW'(e.id));
      check("res_pdt", bus.res_pdt_out, e.pdt);
    end else begin
      check("res_idle", PW'(bus.res_valid_out), '0);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    int g;
    for (int i = 0; i < NREQ; i++) v[i] = 0;
    repeat (n) cycle(g);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, PW'(bus.req_ready_out), '0);
    check({tag, "_mult_a"}, PW'(bus.mult_a_out), '0);
    check({tag, "_mult_b"}, PW'(bus.mult_b_out), '0);
    check({tag, "_res_valid"}, PW'(bus.res_valid_out), '0);
    check({tag, "_res_id"}, PW'(bus.res_id_out), '0);
    check({tag, "_res_pdt"}, bus.res_pdt_out, '0);
    check({tag, "_count"}, PW'(bus.issue_count_out), '0);
  endtask

  initial begin
    int g;
    int c0;
    checks = 0;
    errors = 0;
    rr     = 0;
    cnt    = '0;
    cyc    = 0;
    for (int i = 0; i < NREQ; i++) begin
      v[i] = 0;
      a[i] = '0;
      b[i] = '0;
    end
    drive();

    // Reset state, with a requester already asserting valid.
    v[3] = 1;
    a[3] = 40'd9;
    drive();
    #12;
    check_all_zero("reset");
    v[3] = 0;
    drive();
    @(negedge clk);
    rst_n = 1'b1;

    // All four continuously valid: grants 0,1,2,3,0,... back to back.
    c0 = int'(cnt);
    for (int i = 0; i < NREQ; i++) begin
      v[i] = 1;
      a[i] = WIDTH'(i + 1);
      b[i] = WIDTH'(i + 2);
    end
    repeat (8) cycle(g);
    check("count_after_8", PW'(bus.issue_count_out), PW'(c0 + 8));
    idle(LATENCY + 2);

    // Single requester 2: 3*4 returns on id 2.
    v[2] = 1;
    a[2] = 40'd3;
    b[2] = 40'd4;
    cycle(g);
    v[2] = 0;
    idle(LATENCY + 2);

    // Pointer now at 3: with req 0 and 3 valid, 3 goes first, then wrap to 0.
    v[0] = 1; a[0] = 40'd5; b[0] = 40'd6;
    v[3] = 1; a[3] = 40'd7; b[3] = 40'd8;
    cycle(g);
    v[g] = 0;
    cycle(g);
    v[g] = 0;
    idle(LATENCY + 2);

    // Maximum operands from requester 1.
    v[1] = 1;
    a[1] = '1;
    b[1] = '1;
    cycle(g);
    v[1] = 0;
    idle(LATENCY + 1);
    check("max_pdt_model", bus.res_pdt_out, 80'hFFFFFFFFFE0000000001);

    // Random traffic: requesters hold valid and operands until accepted.
    repeat (400) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          v[i] = 1;
          a[i] = WIDTH'({$urandom(), $urandom()});
          b[i] = WIDTH'({$urandom(), $urandom()});
        end
      end
      cycle(g);
      if (g >= 0) v[g] = 0;
    end
    idle(LATENCY + 2);

    // Reset in the middle of two in-flight operations.
    v[0] = 1; a[0] = 40'd11; b[0] = 40'd13;
    v[1] = 1; a[1] = 40'd17; b[1] = 40'd19;
    cycle(g);
    v[g] = 0;
    cycle(g);
    v[g] = 0;
    #3;
    v[0] = 1;
    drive();
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    q.delete();
    rr  = 0;
    cnt = '0;
    v[0] = 0;
    drive();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(LATENCY + 4);

    // Counter wrap with a lone requester granted every cycle.
    v[1] = 1;
    a[1] = WIDTH'({$urandom(), $urandom()});
    b[1] = WIDTH'({$urandom(), $urandom()});
    repeat (65535) cycle(g);
    check("count_full", PW'(bus.issue_count_out), PW'(16'hFFFF));
    cycle(g);
    check("count_wrap", PW'(bus.issue_count_out), '0);
    v[1] = 0;

    // Gapped traffic: one request every third cycle.
    repeat (6) begin
      v[0] = 1;
      a[0] = WIDTH'({$urandom(), $urandom()});
      b[0] = WIDTH'({$urandom(), $urandom()});
      cycle(g);
      v[0] = 0;
      cycle(g);
      cycle(g);
    end
    idle(LATENCY + 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_rr_scheduler.md
Name: mult_rr_scheduler

Overview:
Round-robin scheduler that shares one pipelined multiplier (WIDTH x WIDTH -> 2*WIDTH, fixed latency) among NREQ requesters. It accepts at most one operand pair per cycle through per-requester valid/ready handshakes and drives the multiplier inputs from registers. It tracks each issued operation's requester ID through a tag pipeline that matches the multiplier latency, and returns each product to its originator. It sits between the signal-processing clients and the single shared multiplier instance.

Parameters:
WIDTH, 40, operand width in bits; product is 2*WIDTH.
NREQ, 4, number of requesters (>=2).
LATENCY, 3, multiplier cycles from registered a/b to valid pdt.
IDW, 2, requester-ID width; equals clog2(NREQ).

Ports:
clk_in  in  1  system clock; all state updates on rising edge.
rst_n_in  in  1  reset; asynchronous, active-low.
req_valid_in  in  NREQ  per-requester operand-valid.
req_a_in  in  NREQ*WIDTH  packed operand A; requester i occupies [i*WIDTH +: WIDTH].
req_b_in  in  NREQ*WIDTH  packed operand B, same packing.
req_ready_out  out  NREQ  one-hot grant; combinational.
mult_a_out  out  WIDTH  registered operand A to multiplier.
mult_b_out  out  WIDTH  registered operand B to multiplier.
mult_pdt_in  in  2*WIDTH  multiplier product.
res_valid_out  out  NREQ  one-hot result strobe; pulses 1 cycle.
res_id_out  out  IDW  ID of current result.
res_pdt_out  out  2*WIDTH  product; valid only while |res_valid_out.
issue_count_out  out  16  total accepted operations; wraps at 65535->0.

Behaviour:
- Reset (rst_n_in=0, asynchronous): rr_ptr=0; mult_a_out=0; mult_b_out=0; tag pipeline valid bits=0; res_valid_out=0; res_id_out=0; res_pdt_out=0; issue_count_out=0. req_ready_out=0 while in reset.
- Arbitration, combinational: search req_valid_in from index rr_ptr upward, wrapping modulo NREQ. The first asserted index i receives req_ready_out[i]=1; all other bits are 0. If no valid is asserted, req_ready_out=0.
- Transfer occurs when req_valid_in[i] & req_ready_out[i]. At most one transfer per cycle. Requesters must hold valid and operands stable until accepted.
- On a transfer at edge T:
  - mult_a_out/mult_b_out load requester i's operands.
  - rr_ptr becomes (i+1) mod NREQ.
  - issue_count_out increments.
  - Tag stage 0 loads {valid=1, id=i}.
- With no transfer: mult_a_out/mult_b_out load 0, tag stage 0 valid=0, and rr_ptr holds.
- Tag pipeline: LATENCY+1 stages advance every cycle. There is no stall and no back-pressure on results.
- Result timing:
  - Edge T registers the operands.
  - mult_pdt_in for that operation is valid LATENCY cycles later.
  - At edge T+LATENCY+1, res_pdt_out registers mult_pdt_in, res_id_out registers the tag id, and res_valid_out registers onehot(id) if the tag is valid, else 0.
  - Total request-accept to result-visible latency: LATENCY+1 cycles after the accepting edge.
- Throughput: one operation per cycle sustained. Back-to-back grants to different requesters produce back-to-back results in the same order.
- Fairness: a continuously asserted requester is granted within NREQ cycles.
- A single requester with constant valid and no competitors is granted every cycle.
- Wrap-around:
  - rr_ptr=NREQ-1 with only req 0 valid: grant 0, and rr_ptr becomes 1.
  - issue_count_out at 0xFFFF plus a transfer gives 0x0000.
- Reset mid-operation: in-flight tags are discarded, and no res_valid_out fires for operations issued before reset. Products arriving afterwards are ignored because their tag valid bits are 0.
- Deasserting valid without a transfer is permitted and has no side effect.
- mult_pdt_in is never interpreted except when the aligned tag is valid.

Test Plan:
- Reset during traffic: issue 2 ops, assert rst_n_in=0 asynchronously mid-cycle -> all outputs 0 immediately; no res_valid_out pulse for the 2 ops after release.
- Single requester: req 2 valid with a=3, b=4 at edge T -> req_ready_out=4'b0100; at edge T+4 (LATENCY=3), res_valid_out=4'b0100, res_id_out=2, res_pdt_out=12.
- All four valid continuously, req i operands a=i+1, b=i+2 -> grants in order 0,1,2,3,0,...; results in order 2,6,12,20, one per cycle, no bubbles; issue_count_out=8 after 8 cycles.
- Round-robin wrap: rr_ptr=3 (after a grant to req 2), only req 0 and req 3 valid -> grant 3 first, then 0; results pdt match each requester's own operands.
- Max operands: a=b=2^40-1 from req 1 -> res_pdt_out=80'hFFFFFFFFFE0000000001, res_id_out=1.
- Counter wrap: preload via 65535 transfers, then one more -> issue_count_out=0; gapped traffic (valid every 3rd cycle) -> res_valid_out pulses exactly 1 cycle each, spaced 3 cycles apart.
